// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : MEM-stage load/store engine. Runs one req/ack bus transaction at
//            a time, with lane steering, load extension, misalign and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  DMType,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rd_out,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [9:0] c_timeout = 10'(TIMEOUT);

  logic [1:0]  r_state;
  logic [9:0]  r_cnt;
  logic [1:0]  r_a;
  logic [2:0]  r_dmt;
  logic        r_req, r_we, r_err;
  logic [31:0] r_addr, r_wdata, r_rd;
  logic [3:0]  r_be;

  logic        w_is_word, w_is_half, w_is_byte, w_mis, w_start_idle;
  logic [3:0]  w_be;
  logic [31:0] w_wd, w_load;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [9:0]  w_cnt_next;
  logic        w_timeout;

  // Codes 101-111 fall back to word accesses.
  assign w_is_word    = (DMType == 3'b000) || (DMType >= 3'b101);
  assign w_is_half    = (DMType == 3'b001) || (DMType == 3'b010);
  assign w_is_byte    = (DMType == 3'b011) || (DMType == 3'b100);
  assign w_mis        = (w_is_word && (addr[1:0] != 2'b00)) || (w_is_half && addr[0]);
  assign w_start_idle = (r_state == S_IDLE) && (MemRead || MemWrite);

  assign misalign = w_start_idle && w_mis;
  assign stall    = (w_start_idle && !w_mis) || (r_state == S_BUSY);

  always_comb begin
    w_be = 4'b1111;
    w_wd = wdata;
    if (!MemWrite) begin
      w_wd = 32'd0;
    end else if (w_is_half) begin
      w_be = addr[1] ? 4'b1100 : 4'b0011;
      w_wd = {2{wdata[15:0]}};
    end else if (w_is_byte) begin
      w_be = 4'b0001 << addr[1:0];
      w_wd = {4{wdata[7:0]}};
    end
  end

  always_comb begin
    case (r_a)
      2'd0:    w_byte = bus_rdata[7:0];
      2'd1:    w_byte = bus_rdata[15:8];
      2'd2:    w_byte = bus_rdata[23:16];
      default: w_byte = bus_rdata[31:24];
    endcase
    w_half = r_a[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (r_dmt)
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b010:  w_load = {16'd0, w_half};
      3'b011:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'd0, w_byte};
      default: w_load = bus_rdata;
    endcase
  end

  // r_cnt holds completed BUSY cycles; ack in the final cycle still wins.
  assign w_cnt_next = r_cnt + 10'd1;
  assign w_timeout  = !bus_ack && (w_cnt_next == c_timeout);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= 10'd0;
      r_a     <= 2'd0;
      r_dmt   <= 3'd0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
      r_rd    <= 32'd0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_idle) begin
            if (w_mis) begin
              r_rd <= 32'd0;
            end else begin
              r_req   <= 1'b1;
              r_we    <= MemWrite;
              r_addr  <= {addr[31:2], 2'b00};
              r_be    <= w_be;
              r_wdata <= w_wd;
              r_a     <= addr[1:0];
              r_dmt   <= DMType;
              r_cnt   <= 10'd0;
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          r_cnt <= w_cnt_next;
          if (bus_ack) begin
            r_req <= 1'b0;
            if (!r_we) r_rd <= w_load;
            r_state <= S_DONE;
          end else if (w_timeout) begin
            r_req   <= 1'b0;
            r_err   <= 1'b1;
            r_rd    <= 32'd0;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_out    = r_rd;
  assign bus_err   = r_err;
  assign bus_req   = r_req;
  assign bus_we    = r_we;
  assign bus_addr  = r_addr;
  assign bus_be    = r_be;
  assign bus_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Directed self-checking bench for mem_access_unit (TIMEOUT=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        MemRead, MemWrite, bus_ack;
  logic [2:0]  DMType;
  logic [31:0] addr, wdata, bus_rdata;
  logic [31:0] rd_out, bus_addr, bus_wdata;
  logic        stall, misalign, bus_err, bus_req, bus_we;
  logic [3:0]  bus_be;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rstn(rstn), .MemRead(MemRead), .MemWrite(MemWrite),
    .DMType(DMType), .addr(addr), .wdata(wdata), .rd_out(rd_out),
    .stall(stall), .misalign(misalign), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Single access acked on its first BUSY cycle.
  task automatic run(input string tag, input logic r, input logic w, input logic [2:0] t,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdata,
                     input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] erd);
    @(negedge clk);
    MemRead = r; MemWrite = w; DMType = t; addr = a; wdata = wd;
    #1;
    chk({tag, ".stall_start"}, 32'(stall), 32'd1);
    chk({tag, ".misalign"}, 32'(misalign), 32'd0);
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0;
    #1;
    chk({tag, ".bus_req"}, 32'(bus_req), 32'd1);
    chk({tag, ".bus_addr"}, bus_addr, {a[31:2], 2'b00});
    chk({tag, ".bus_be"}, 32'(bus_be), 32'(ebe));
    chk({tag, ".bus_we"}, 32'(bus_we), 32'(w));
    chk({tag, ".bus_wdata"}, bus_wdata, ewd);
    chk({tag, ".stall_busy"}, 32'(stall), 32'd1);
    bus_ack = 1'b1; bus_rdata = rdata;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    chk({tag, ".stall_done"}, 32'(stall), 32'd0);
    chk({tag, ".req_done"}, 32'(bus_req), 32'd0);
    chk({tag, ".rd_out"}, rd_out, erd);
    chk({tag, ".bus_err"}, 32'(bus_err), 32'd0);
  endtask

  task automatic mis(input string tag, input logic [2:0] t, input logic [31:0] a);
    @(negedge clk);
    MemRead = 1'b1; DMType = t; addr = a;
    #1;
    chk({tag, ".misalign"}, 32'(misalign), 32'd1);
    chk({tag, ".stall"}, 32'(stall), 32'd0);
    @(negedge clk);
    MemRead = 1'b0;
    #1;
    chk({tag, ".no_req"}, 32'(bus_req), 32'd0);
    chk({tag, ".rd_out"}, rd_out, 32'd0);
    chk({tag, ".pulse_end"}, 32'(misalign), 32'd0);
  endtask

  initial begin
    rstn = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; DMType = 3'd0;
    addr = 32'd0; wdata = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
    #12;
    chk("rst.bus_req", 32'(bus_req), 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.rd_out", rd_out, 32'd0);
    chk("rst.bus_addr", bus_addr, 32'd0);
    chk("rst.bus_be", 32'(bus_be), 32'd0);
    chk("rst.bus_err", 32'(bus_err), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    run("lw",  1'b1, 1'b0, 3'b000, 32'h100, 32'h0, 32'hDEADBEEF, 4'hF, 32'h0, 32'hDEADBEEF);
    run("lb",  1'b1, 1'b0, 3'b011, 32'h203, 32'h0, 32'h80FF7F01, 4'hF, 32'h0, 32'hFFFFFF80);
    run("lbu", 1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF7F01, 4'hF, 32'h0, 32'h00000080);
    run("lh",  1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 32'h80FF7F01, 4'hF, 32'h0, 32'hFFFF80FF);
    run("lhu", 1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'h80FF7F01, 4'hF, 32'h0, 32'h00007F01);
    // Stores leave rd_out at the previous load result.
    run("sb",  1'b0, 1'b1, 3'b011, 32'h301, 32'h12345678, 32'h0, 4'b0010, 32'h78787878, 32'h00007F01);
    run("sh",  1'b0, 1'b1, 3'b001, 32'h302, 32'h12345678, 32'h0, 4'b1100, 32'h56785678, 32'h00007F01);
    run("sw",  1'b1, 1'b1, 3'b000, 32'h300, 32'h12345678, 32'h0, 4'b1111, 32'h12345678, 32'h00007F01);

    // Reset during BUSY
    @(negedge clk);
    MemRead = 1'b1; DMType = 3'b000; addr = 32'h500;
    @(negedge clk);
    MemRead = 1'b0;
    #1;
    chk("rstbusy.req_before", 32'(bus_req), 32'd1);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("rstbusy.bus_req", 32'(bus_req), 32'd0);
    chk("rstbusy.stall", 32'(stall), 32'd0);
    chk("rstbusy.bus_addr", bus_addr, 32'd0);
    chk("rstbusy.rd_out", rd_out, 32'd0);
    chk("rstbusy.bus_err", 32'(bus_err), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    run("lw_after_rst", 1'b1, 1'b0, 3'b000, 32'h104, 32'h0, 32'hCAFEF00D, 4'hF, 32'h0, 32'hCAFEF00D);

    mis("mis_lw", 3'b000, 32'h102);
    mis("mis_lh", 3'b001, 32'h101);

    // Ack while idle must not start anything
    @(negedge clk);
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    chk("idle_ack.bus_req", 32'(bus_req), 32'd0);
    chk("idle_ack.stall", 32'(stall), 32'd0);

    // Load a nonzero value, then time out on a second load
    run("lw_pre_to", 1'b1, 1'b0, 3'b000, 32'h10, 32'h0, 32'h0BADF00D, 4'hF, 32'h0, 32'h0BADF00D);
    @(negedge clk);
    MemRead = 1'b1; DMType = 3'b000; addr = 32'h400;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      MemRead = 1'b0;
      #1;
      chk($sformatf("to.stall_busy%0d", i), 32'(stall), 32'd1);
      chk($sformatf("to.err_busy%0d", i), 32'(bus_err), 32'd0);
    end
    @(negedge clk);
    #1;
    chk("to.bus_err", 32'(bus_err), 32'd1);
    chk("to.stall", 32'(stall), 32'd0);
    chk("to.bus_req", 32'(bus_req), 32'd0);
    chk("to.rd_out", rd_out, 32'd0);
    @(negedge clk);
    #1;
    chk("to.err_pulse_end", 32'(bus_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage load/store engine of the pipelined CPU. It consumes the `MemRead`, `MemWrite` and `DMType` controls produced by instruction decode and runs a single-outstanding req/ack transaction on the data bus. It handles byte-lane steering, write replication, load sign/zero extension, misalignment detection and bus timeout. While a transaction is in flight it holds the pipeline with `stall`.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum BUSY cycles waiting for `bus_ack` before aborting; range 1..1023.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `MemRead` in 1: load request from the MEM-stage pipeline register.
- `MemWrite` in 1: store request.
- `DMType` in 3: access size. 000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned. Codes 101–111 are treated as word.
- `addr` in 32: effective byte address (ALU result).
- `wdata` in 32: store data (rs2).
- `rd_out` out 32: formatted load result; valid in the DONE cycle.
- `stall` out 1: holds IF/ID/EX/MEM pipeline registers.
- `misalign` out 1: one-cycle pulse on a misaligned access.
- `bus_err` out 1: one-cycle pulse on timeout.
- `bus_req` out 1, `bus_we` out 1, `bus_addr` out 32, `bus_be` out 4, `bus_wdata` out 32: bus request side, all registered.
- `bus_ack` in 1, `bus_rdata` in 32: bus response side.

## Operation
- States are IDLE, BUSY and DONE.
- `start = MemRead | MemWrite`, sampled only in IDLE. If both are high, the access is a store.
- Misaligned means word with `addr[1:0]!=0`, or half/half-unsigned with `addr[0]=1`. On a misaligned `start` in IDLE:
  - no bus transaction;
  - `misalign=1` for that cycle;
  - `stall=0`;
  - the state stays IDLE;
  - `rd_out` is cleared to 0 on the next edge.
- On an aligned `start` in IDLE:
  - `stall=1` combinationally;
  - at the edge, latch the bus fields, `addr[1:0]`, `DMType` and the write flag; set `bus_req=1`; go to BUSY.
- Bus field values:
  - `bus_addr = {addr[31:2],2'b00}`.
  - Loads: `bus_we=0`, `bus_be=4'b1111`, `bus_wdata=0`.
  - Store word: `bus_be=1111`, data unchanged.
  - Store half: `bus_be` is 0011 (`addr[1]=0`) or 1100 (`addr[1]=1`); data = `{2{wdata[15:0]}}`.
  - Store byte: `bus_be = 4'b0001<<addr[1:0]`; data = `{4{wdata[7:0]}}`.
- BUSY:
  - `stall=1`; all bus outputs are held stable.
  - A cycle counter increments.
  - On `bus_ack=1`: deassert `bus_req` at the edge. For loads, register the formatted result into `rd_out`. Go to DONE.
  - If the counter reaches `TIMEOUT` without ack: deassert `bus_req`, `bus_err=1` for one cycle, `rd_out=0`, go to DONE.
- Load formatting uses the latched `addr[1:0]` and `DMType`:
  - select the byte `bus_rdata[8*a+7:8*a]` or halfword `bus_rdata[16*a1+15:16*a1]`;
  - signed types sign-extend from bit 7/15, unsigned types zero-extend;
  - word passes through.
- DONE: `stall=0` so the pipeline advances past the instruction; `rd_out` is held. The next state is IDLE, and inputs are ignored in DONE.
- Stores leave `rd_out` unchanged.
- `bus_ack` seen while in IDLE or DONE is ignored.

## Timing
- Reset (async, immediate): state IDLE; `bus_req`, `bus_we`, `bus_addr`, `bus_be`, `bus_wdata`, `rd_out`, counter, `misalign`, `bus_err` all 0; `stall=0`.
- Reset asserted mid-BUSY drops `bus_req` immediately. No completion and no `bus_err` is reported.
- `bus_req` first appears the cycle after `start` in IDLE.
- Best case is ack in the first BUSY cycle. `stall` is then high for 2 cycles (IDLE-start, BUSY), and `rd_out` is valid in the 3rd cycle (DONE).
- General case: stall cycles = 1 + number of BUSY cycles.
- Timeout: `bus_err` is asserted in the DONE cycle, after exactly `TIMEOUT` BUSY cycles.
- Back-to-back accesses: a new `start` is accepted in the IDLE cycle following DONE. This gives a minimum spacing of 3 cycles per access.
- `misalign` and `stall` are combinational from IDLE state and the inputs. All other outputs are registered.

## Test plan
- Load word: `MemRead=1`, `DMType=000`, `addr=0x100`, ack on the first BUSY cycle with `bus_rdata=0xDEADBEEF` -> `bus_addr=0x100`, `bus_be=1111`; `stall` is high for 2 cycles; `rd_out=0xDEADBEEF` in DONE.
- Byte/half extension with `bus_rdata=0x80FF7F01`:
  - lb at `addr=0x203` -> `0xFFFFFF80`;
  - lbu at `addr=0x203` -> `0x00000080`;
  - lh at `addr=0x202` -> `0xFFFF80FF`;
  - lhu at `addr=0x200` -> `0x00007F01`.
- Stores with `wdata=0x12345678`:
  - sb at `0x301` -> `be=0010`, data `0x78787878`;
  - sh at `0x302` -> `be=1100`, data `0x56785678`;
  - sw at `0x300` -> `be=1111`, `bus_we=1`.
- Misalign: lw at `0x102` and lh at `0x101` -> `misalign` pulse, no `bus_req`, `stall=0`, `rd_out=0`.
- Timeout with `TIMEOUT=4` and ack never asserted -> 4 BUSY cycles, then `bus_err` pulse, `rd_out=0`, `stall` released.
- `rstn` pulled low during BUSY with ack delayed by 10 cycles -> `bus_req=0` immediately, all outputs 0; a fresh lw after release completes normally.
